buffer_read_controller_filter_multi: RTL and testbench



---
 rtl/buffer_read_controller_filter_multi.sv | 116 +++++++++++
 tb/tb_buffer_read_controller_filter_multi.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_read_controller_filter_multi.sv
// Drains 1..MAX_FILTERS filters from the FWFT buffer into the scratchpad; pop and write happen in the same cycle (0 latency).
// stall/valid=0 hold all counters; init aborts and restarts. BUF_RD_CTRL_PERF_EN adds the stall_cycles counter.
module buffer_read_controller_filter_multi #(
  parameter int SPAD_ADDR_WIDTH = 4,
  parameter int FILTER_SIZE     = 4,
  parameter int MAX_FILTERS     = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic [CNT_WIDTH-1:0]       num_filters,
  input  logic                       valid,
  input  logic                       stall,
  output logic                       ren_buf,
  output logic                       wen_spad,
  output logic [SPAD_ADDR_WIDTH-1:0] spad_waddr,
  output logic [CNT_WIDTH-1:0]       filter_idx,
  output logic                       valid_end,
  output logic                       busy,
`ifdef BUF_RD_CTRL_PERF_EN
  output logic [15:0]                stall_cycles,
`endif
  output logic                       done
);

  localparam int WCW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam logic [WCW-1:0]             WORD_LAST = WCW'(FILTER_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]       MAXF      = CNT_WIDTH'(MAX_FILTERS);
  localparam logic [CNT_WIDTH-1:0]       ONE_F     = CNT_WIDTH'(1);
  localparam logic [WCW-1:0]             ONE_W     = WCW'(1);
  localparam logic [SPAD_ADDR_WIDTH-1:0] ONE_A     = SPAD_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                     state_q;
  logic [WCW-1:0]             word_cnt_q;
  logic [CNT_WIDTH-1:0]       filter_idx_q;
  logic [CNT_WIDTH-1:0]       nf_q;
  logic [CNT_WIDTH-1:0]       nf_d;
  logic [SPAD_ADDR_WIDTH-1:0] spad_waddr_q;
  logic                       xfer;
  logic                       word_last;
  logic                       filter_last;

  always_comb begin
    nf_d = num_filters;
    if (num_filters == '0)
      nf_d = ONE_F;
    else if (num_filters > MAXF)
      nf_d = MAXF;
  end

  // init wins over a transfer so an abort never pops a word it then discards
  assign xfer        = ~rst & ~init & (state_q == LOAD) & valid & ~stall;
  assign word_last   = (word_cnt_q == WORD_LAST);
  assign filter_last = (filter_idx_q == nf_q - ONE_F);

  assign ren_buf    = xfer;
  assign wen_spad   = xfer;
  assign valid_end  = xfer & word_last;
  assign busy       = ~rst & (state_q != IDLE);
  assign done       = ~rst & (state_q == DONE);
  assign spad_waddr = spad_waddr_q;
  assign filter_idx = filter_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      filter_idx_q <= '0;
      spad_waddr_q <= '0;
      nf_q         <= '0;
    end else if (init) begin
      state_q      <= LOAD;
      word_cnt_q   <= '0;
      filter_idx_q <= '0;
      spad_waddr_q <= '0;
      nf_q         <= nf_d;
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer) begin
            spad_waddr_q <= spad_waddr_q + ONE_A;
            if (word_last) begin
              word_cnt_q <= '0;
              // filter_idx stays on the last filter once the load completes
              if (filter_last)
                state_q <= DONE;
              else
                filter_idx_q <= filter_idx_q + ONE_F;
            end else begin
              word_cnt_q <= word_cnt_q + ONE_W;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BUF_RD_CTRL_PERF_EN
  logic [15:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst || init)
      stall_cycles_q <= '0;
    else if ((state_q == LOAD) && !xfer && (stall_cycles_q != 16'hFFFF))
      stall_cycles_q <= stall_cycles_q + 16'd1;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_buffer_read_controller_filter_multi.sv
// Directed bench: FWFT buffer queue and scratchpad array around the controller, hand-computed expectations.
module tb_buffer_read_controller_filter_multi;
  localparam int SAW = 4;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           init = 1'b0;
  logic [CW-1:0]  num_filters = '0;
  logic           valid = 1'b0;
  logic           stall = 1'b0;
  logic           ren_buf, wen_spad, valid_end, busy, done;
  logic [SAW-1:0] spad_waddr;
  logic [CW-1:0]  filter_idx;
`ifdef BUF_RD_CTRL_PERF_EN
  logic [15:0]    stall_cycles;
`endif

  buffer_read_controller_filter_multi #(
    .SPAD_ADDR_WIDTH(SAW), .FILTER_SIZE(4), .MAX_FILTERS(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .num_filters(num_filters),
    .valid(valid), .stall(stall), .ren_buf(ren_buf), .wen_spad(wen_spad),
    .spad_waddr(spad_waddr), .filter_idx(filter_idx), .valid_end(valid_end),
    .busy(busy),
`ifdef BUF_RD_CTRL_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int q[$];
  int spad[16];
  int wa[64], wd[64], wfi[64], wcyc[64], waddr_at[64], busy_at[64];
  logic wve[64];
  int nw, done_cnt, done_cyc, rw_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic fill(input int n);
    q.delete();
    for (int i = 1; i <= n; i++) q.push_back(i);
  endtask

  function automatic logic [15:0] ve_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) if (i < nw) v[i] = wve[i];
    return v;
  endfunction

  // One load: init on cycle 0 (plus in_m), stall/valid gaps per cycle mask, bounded to 64 cycles
  task automatic run(input int nf, input logic [63:0] st_m, input logic [63:0] nv_m,
                     input logic [63:0] in_m);
    logic cap_ren;
    nw = 0; done_cnt = 0; done_cyc = -1; rw_mis = 0;
    num_filters = CW'(nf);
    for (int c = 0; c < 64; c++) begin
      init  = (c == 0) | in_m[c];
      stall = st_m[c];
      valid = (q.size() > 0) & ~nv_m[c];
      #1;
      waddr_at[c] = int'(spad_waddr);
      busy_at[c]  = int'(busy);
      if (ren_buf !== wen_spad) rw_mis++;
      cap_ren = ren_buf;
      if (wen_spad === 1'b1 && q.size() > 0) begin
        wa[nw] = int'(spad_waddr); wd[nw] = q[0]; wve[nw] = valid_end;
        wfi[nw] = int'(filter_idx); wcyc[nw] = c;
        spad[spad_waddr] = q[0];
        nw++;
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = c; end
      @(posedge clk);
      if (cap_ren === 1'b1 && q.size() > 0) void'(q.pop_front());
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    init = 1'b0; stall = 1'b0; valid = 1'b0;
  endtask

  initial begin
    logic [63:0] st_m, nv_m, in_m;
    int gap_wr;

    // reset with valid high
    rst = 1'b1; valid = 1'b1;
    @(negedge clk);
    chk("rst_ren", ren_buf, 0);
    chk("rst_wen", wen_spad, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    chk("rst_waddr", spad_waddr, 0);
    chk("rst_ren2", ren_buf, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ren", ren_buf, 0);
    chk("idle_busy", busy, 0);
    valid = 1'b0;

    // single filter
    fill(4);
    run(1, '0, '0, '0);
    chk("A_nw", nw, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("A_addr%0d", i), wa[i], i);
      chk($sformatf("A_data%0d", i), wd[i], i + 1);
    end
    chk("A_ve", ve_vec(), 16'h0008);
    chk("A_done_cnt", done_cnt, 1);
    chk("A_done_cyc", done_cyc, 5);
    chk("A_busy", busy_at[1], 1);
    chk("A_empty", q.size(), 0);
    chk("A_ren_eq_wen", rw_mis, 0);
    chk("A_idle_after", busy, 0);

    // three filters back to back
    fill(12);
    run(3, '0, '0, '0);
    chk("B_nw", nw, 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("B_addr%0d", i), wa[i], i);
      chk($sformatf("B_fidx%0d", i), wfi[i], i / 4);
    end
    chk("B_ve", ve_vec(), 16'h0888);
    chk("B_done_cnt", done_cnt, 1);
    chk("B_done_cyc", done_cyc, 13);
    chk("B_empty", q.size(), 0);

    // stall on cycles 3..5, valid dropped on 8..9
    for (int i = 0; i < 16; i++) spad[i] = 0;
    st_m = '0; nv_m = '0;
    st_m[3] = 1'b1; st_m[4] = 1'b1; st_m[5] = 1'b1;
    nv_m[8] = 1'b1; nv_m[9] = 1'b1;
    fill(12);
    run(3, st_m, nv_m, '0);
    chk("C_nw", nw, 12);
    gap_wr = 0;
    for (int i = 0; i < nw; i++)
      if (wcyc[i] inside {3, 4, 5, 8, 9}) gap_wr++;
    chk("C_gap_writes", gap_wr, 0);
    chk("C_hold_addr3", waddr_at[3], 2);
    chk("C_hold_addr5", waddr_at[5], 2);
    chk("C_hold_addr9", waddr_at[9], 4);
    for (int i = 0; i < 12; i++) chk($sformatf("C_spad%0d", i), spad[i], i + 1);
    chk("C_done_cyc", done_cyc, 18);
    chk("C_ren_eq_wen", rw_mis, 0);
`ifdef BUF_RD_CTRL_PERF_EN
    chk("C_stall_cycles", stall_cycles, 5);
`endif

    // abort after six words of a two-filter load
    in_m = '0; in_m[7] = 1'b1;
    fill(14);
    run(2, '0, '0, in_m);
    chk("D_nw", nw, 14);
    chk("D_addr6", wa[6], 0);
    chk("D_data6", wd[6], 7);
    chk("D_cyc6", wcyc[6], 8);
    chk("D_addr13", wa[13], 7);
    chk("D_ve", ve_vec(), 16'h2208);
    chk("D_done_cnt", done_cnt, 1);
    chk("D_done_cyc", done_cyc, 16);
    chk("D_empty", q.size(), 0);
`ifdef BUF_RD_CTRL_PERF_EN
    chk("D_stall_cycles", stall_cycles, 0);
`endif

    // num_filters=0 clamps to one filter
    fill(6);
    run(0, '0, '0, '0);
    chk("E_nw", nw, 4);
    chk("E_done_cyc", done_cyc, 5);
    chk("E_left", q.size(), 2);
    q.delete();

    // num_filters=7 clamps to four filters
    fill(16);
    run(7, '0, '0, '0);
    chk("F_nw", nw, 16);
    chk("F_addr15", wa[15], 15);
    chk("F_fidx15", wfi[15], 3);
    chk("F_done_cyc", done_cyc, 17);
    chk("F_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
